// File: rtl/md5_pkg.sv
// Shared MD5 constants, round schedule helpers and packed-BCD arithmetic.
// Used by the range search engine and by the top-level millisecond timer.
package md5_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NORM,
    ST_HASH,
    ST_CHECK,
    ST_FIN
  } state_t;

  localparam logic [31:0] A0 = 32'h67452301;
  localparam logic [31:0] B0 = 32'hefcdab89;
  localparam logic [31:0] C0 = 32'h98badcfe;
  localparam logic [31:0] D0 = 32'h10325476;
  localparam logic [31:0] BCD_MAX = 32'h99999999;

  localparam logic [31:0] K [0:63] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  function automatic logic [4:0] shift_amt(input logic [5:0] r);
    case ({r[5:4], r[1:0]})
      4'h0: return 5'd7;   4'h1: return 5'd12;  4'h2: return 5'd17;  4'h3: return 5'd22;
      4'h4: return 5'd5;   4'h5: return 5'd9;   4'h6: return 5'd14;  4'h7: return 5'd20;
      4'h8: return 5'd4;   4'h9: return 5'd11;  4'ha: return 5'd16;  4'hb: return 5'd23;
      4'hc: return 5'd6;   4'hd: return 5'd10;  4'he: return 5'd15;  default: return 5'd21;
    endcase
  endfunction

  // Message word index per round; arithmetic is mod 16 so only r[3:0] matters.
  function automatic logic [3:0] msg_idx(input logic [5:0] r);
    case (r[5:4])
      2'd0:    return r[3:0];
      2'd1:    return r[3:0] * 4'd5 + 4'd1;
      2'd2:    return r[3:0] * 4'd3 + 4'd5;
      default: return r[3:0] * 4'd7;
    endcase
  endfunction

  // Adds one at digit position pos; bit 32 is the carry out of the top digit.
  function automatic logic [32:0] bcd_add1(input logic [31:0] v, input int pos);
    logic [31:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (c && i >= pos) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'h0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  function automatic logic [31:0] bcd_inc(input logic [31:0] v);
    logic [32:0] t;
    t = bcd_add1(v, 0);
    return t[31:0];
  endfunction

  // Rounds an invalid BCD value up to the next valid one; bit 32 flags overflow.
  function automatic logic [32:0] bcd_normalise(input logic [31:0] v);
    logic [31:0] upper;
    logic [32:0] r;
    int          p;
    upper = v;
    p = -1;
    for (int i = 7; i >= 0; i--) begin
      if (p < 0 && v[4*i +: 4] > 4'd9) p = i;
    end
    for (int i = 0; i < 8; i++) begin
      if (i <= p) upper[4*i +: 4] = 4'h0;
    end
    if (p < 0) r = {1'b0, v};
    else       r = bcd_add1(upper, p + 1);
    return r;
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [127:0] md5_digest(input logic [31:0] a, b, c, d);
    return {bswap32(a), bswap32(b), bswap32(c), bswap32(d)};
  endfunction

endpackage

// File: rtl/md5_core.sv
// Iterative MD5 compression: load latches the block and IVs, each step runs one round.
module md5_core
  import md5_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         step,
  input  logic [511:0] block,
  output logic         last,
  output logic [127:0] digest
);

  logic [31:0]  a_q, b_q, c_q, d_q, a_d, b_d, c_d, d_d;
  logic [511:0] blk_q, blk_d;
  logic [5:0]   rnd_q, rnd_d;
  logic [31:0]  f, m, t, rot;

  always_comb begin
    case (rnd_q[5:4])
      2'd0:    f = (b_q & c_q) | (~b_q & d_q);
      2'd1:    f = (b_q & d_q) | (c_q & ~d_q);
      2'd2:    f = b_q ^ c_q ^ d_q;
      default: f = c_q ^ (b_q | ~d_q);
    endcase
    m   = blk_q[{msg_idx(rnd_q), 5'd0} +: 32];
    t   = a_q + f + K[rnd_q] + m;
    rot = 32'(({t, t} << shift_amt(rnd_q)) >> 32);

    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    d_d   = d_q;
    blk_d = blk_q;
    rnd_d = rnd_q;
    if (load) begin
      a_d   = A0;
      b_d   = B0;
      c_d   = C0;
      d_d   = D0;
      blk_d = block;
      rnd_d = 6'd0;
    end else if (step) begin
      a_d   = d_q;
      b_d   = b_q + rot;
      c_d   = b_q;
      d_d   = c_q;
      rnd_d = rnd_q + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q   <= A0;
      b_q   <= B0;
      c_q   <= C0;
      d_q   <= D0;
      blk_q <= '0;
      rnd_q <= 6'd0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      d_q   <= d_d;
      blk_q <= blk_d;
      rnd_q <= rnd_d;
    end
  end

  assign last   = (rnd_q == 6'(ROUNDS - 1));
  assign digest = md5_digest(a_q + A0, b_q + B0, c_q + C0, d_q + D0);

endmodule

// File: rtl/md5_range_search.sv
// Brute-force search of one slice of the 8-digit BCD password space against an MD5 target.
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_NORM  | round low up to valid BCD, reject empty range
//   ST_HASH  | 64 MD5 rounds on cand
//   ST_CHECK | compare digest, advance or finish
//   ST_FIN   | result held until start drops
module md5_range_search
  import md5_pkg::*;
#(
  parameter int PASS_DIGITS = 8,
  parameter int ROUNDS      = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [31:0]  low,
  input  logic [31:0]  high,
  input  logic [127:0] hash,
  output logic         done,
  output logic         found,
  output logic [31:0]  pass,
  output logic [31:0]  cand
);

  state_t       state_q, state_d;
  logic         done_q, done_d, found_q, found_d;
  logic [31:0]  pass_q, pass_d, cand_q, cand_d;
  logic [32:0]  norm;
  logic         core_load, core_step, core_last;
  logic [127:0] core_digest;
  logic [511:0] block;

  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    found_d   = found_q;
    pass_d    = pass_q;
    cand_d    = cand_q;
    core_load = 1'b0;
    core_step = 1'b0;
    norm      = bcd_normalise(low);
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_NORM;
      ST_NORM: begin
        if (!start) begin
          state_d = ST_IDLE;
        end else if (norm[32] || norm[31:0] > high) begin
          done_d  = 1'b1;
          state_d = ST_FIN;
        end else begin
          cand_d    = norm[31:0];
          core_load = 1'b1;
          state_d   = ST_HASH;
        end
      end
      ST_HASH: begin
        if (!start) begin
          state_d = ST_IDLE;
        end else begin
          core_step = 1'b1;
          if (core_last) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!start) begin
          state_d = ST_IDLE;
        end else if (core_digest == hash) begin
          found_d = 1'b1;
          done_d  = 1'b1;
          pass_d  = cand_q;
          state_d = ST_FIN;
        end else if (cand_q == high || cand_q == BCD_MAX) begin
          done_d  = 1'b1;
          state_d = ST_FIN;
        end else begin
          cand_d    = bcd_inc(cand_q);
          core_load = 1'b1;
          state_d   = ST_HASH;
        end
      end
      ST_FIN: begin
        if (!start) begin
          done_d  = 1'b0;
          found_d = 1'b0;
          pass_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Single padded block for an 8-byte ASCII message; first character in the low byte.
  always_comb begin
    block = '0;
    for (int i = 0; i < PASS_DIGITS; i++) begin
      block[8*i +: 8] = {4'h3, cand_d[31-4*i -: 4]};
    end
    block[64 +: 32]  = 32'h0000_0080;
    block[448 +: 32] = 32'd64;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      pass_q  <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      found_q <= found_d;
      pass_q  <= pass_d;
      cand_q  <= cand_d;
    end
  end

  md5_core #(
    .ROUNDS (ROUNDS)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (core_load),
    .step    (core_step),
    .block   (block),
    .last    (core_last),
    .digest  (core_digest)
  );

  assign done  = done_q;
  assign found = found_q;
  assign pass  = pass_q;
  assign cand  = cand_q;

endmodule

// File: tb/tb_md5_range_search.sv
// Self-checking bench for md5_range_search: directed vector table, abort/reset sequences,
// and random ranges checked against a decimal-arithmetic search model with its own MD5.
module tb_md5_range_search;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  low = '0, high = '0;
  logic [127:0] hash = '0;
  logic         done, found;
  logic [31:0]  pass, cand;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] kt [64];

  typedef struct {
    logic [31:0]  lo, hi;
    logic [127:0] h;
    logic         ef;
    logic [31:0]  ep;
    int           ecyc;
    logic         use_cand;
    logic [31:0]  ecand;
    logic         chk_first;
    logic [31:0]  c1;
    logic         trace;
    logic [31:0]  c2;
  } vec_t;

  localparam logic [127:0] H1 = 128'he8cd0953abdfde433dfec7faa70df7f6;
  localparam logic [127:0] H0 = 128'hdd4b21e9ef71e1291183a46b913ae6f2;

  md5_range_search dut (
    .clk(clk), .reset_n(reset_n), .start(start), .low(low), .high(high), .hash(hash),
    .done(done), .found(found), .pass(pass), .cand(cand)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [127:0] ref_md5(input logic [31:0] pw);
    logic [7:0]  msg [64];
    logic [31:0] w [16];
    logic [31:0] a, b, c, d, f, t, r;
    int g, s;
    int sh [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};
    for (int i = 0; i < 64; i++) msg[i] = 8'h00;
    for (int i = 0; i < 8; i++) msg[i] = 8'h30 + {4'h0, pw[31-4*i -: 4]};
    msg[8]  = 8'h80;
    msg[56] = 8'd64;
    for (int j = 0; j < 16; j++) w[j] = {msg[4*j+3], msg[4*j+2], msg[4*j+1], msg[4*j]};
    a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0:       begin f = (b & c) | (~b & d); g = i; end
        1:       begin f = (b & d) | (c & ~d); g = (5 * i + 1) % 16; end
        2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
        default: begin f = c ^ (b | ~d);       g = (7 * i) % 16; end
      endcase
      s = sh[i / 16][i % 4];
      t = a + f + kt[i] + w[g];
      r = (t << s) | (t >> (32 - s));
      a = d; d = c; c = b; b = b + r;
    end
    a += 32'h67452301; b += 32'hefcdab89; c += 32'h98badcfe; d += 32'h10325476;
    return {a[7:0], a[15:8], a[23:16], a[31:24], b[7:0], b[15:8], b[23:16], b[31:24],
            c[7:0], c[15:8], c[23:16], c[31:24], d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [31:0] to_bcd(input longint n);
    logic [31:0] r;
    longint x = n;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // First candidate as a decimal number; anything above 99999999 means overflow.
  function automatic longint ref_start(input logic [31:0] lo);
    int p = -1;
    longint u = 0, pw = 1;
    for (int i = 7; i >= 0; i--) if (p < 0 && lo[4*i +: 4] > 4'd9) p = i;
    if (p < 0) begin
      for (int i = 7; i >= 0; i--) u = u * 10 + longint'(lo[4*i +: 4]);
      return u;
    end
    for (int i = 7; i > p; i--) u = u * 10 + longint'(lo[4*i +: 4]);
    for (int i = 0; i <= p; i++) pw = pw * 10;
    return (u + 1) * pw;
  endfunction

  function automatic vec_t ref_search(input logic [31:0] lo, hi, input logic [127:0] h);
    vec_t v;
    longint n;
    int k = 0;
    logic fin = 1'b0;
    logic [31:0] c = '0;
    v = '{lo, hi, h, 1'b0, 32'h0, 2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    n = ref_start(lo);
    if (n > 64'd99999999 || to_bcd(n) > hi) return v;
    while (!fin && k < 200) begin
      k++;
      c = to_bcd(n);
      if (ref_md5(c) == h) begin
        v.ef = 1'b1; v.ep = c; fin = 1'b1;
      end else if (c == hi || n == 99999999) fin = 1'b1;
      else n++;
    end
    v.ecyc = 65 * k + 2;
    v.use_cand = 1'b1;
    v.ecand = c;
    return v;
  endfunction

  // ---------------- stimulus ----------------
  // Called just after a negedge; cycle c in the timing rules is sampled after edge c-1.
  task automatic run_case(input vec_t v, input string nm);
    int cyc = 0;
    logic seen = 1'b0;
    low = v.lo; high = v.hi; hash = v.h; start = 1'b1;
    @(posedge clk);
    while (!seen && cyc < v.ecyc + 10) begin
      @(negedge clk);
      if (v.chk_first && cyc == 1) chk({nm, " cand@2"}, cand, v.c1);
      if (v.trace && (cyc == 64 || cyc == 65)) chk({nm, " cand@65/66"}, cand, v.c1);
      if (v.trace && cyc == 66) chk({nm, " cand@67"}, cand, v.c2);
      if (done) seen = 1'b1;
      else begin @(posedge clk); cyc++; end
    end
    chk({nm, " done_cycle"}, seen ? cyc + 1 : -1, v.ecyc);
    chk({nm, " found"}, found, v.ef);
    chk({nm, " pass"}, pass, v.ep);
    if (v.use_cand) chk({nm, " cand_fin"}, cand, v.ecand);
    @(posedge clk); @(negedge clk);
    chk({nm, " fin_hold"}, {done, found, pass}, {1'b1, v.ef, v.ep});
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({nm, " clear"}, {done, found, pass}, 34'h0);
    if (v.use_cand) chk({nm, " cand_held"}, cand, v.ecand);
  endtask

  function automatic vec_t mkv(input logic [31:0] lo, hi, input logic [127:0] h, input logic ef,
                               input logic [31:0] ep, input int ecyc, input logic uc,
                               input logic [31:0] ecand, input logic cf, input logic [31:0] c1,
                               input logic tr, input logic [31:0] c2);
    vec_t v;
    v = '{lo, hi, h, ef, ep, ecyc, uc, ecand, cf, c1, tr, c2};
    return v;
  endfunction

  initial begin
    vec_t vecs [10];
    vec_t rv;
    longint n0, nh;
    int w;
    logic [31:0] lo_r, tgt;
    logic any_done;
    real x;

    for (int i = 0; i < 64; i++) begin
      x = $sin(real'(i + 1));
      if (x < 0.0) x = -x;
      x = $floor(x * 4294967296.0);
      if (x >= 2147483648.0) kt[i] = 32'($rtoi(x - 4294967296.0));
      else                   kt[i] = 32'($rtoi(x));
    end

    vecs[0] = mkv(32'h53589790, 32'h53589799, H1, 1, 32'h53589793, 262, 1, 32'h53589793, 1, 32'h53589790, 0, 0);
    vecs[1] = mkv(32'h0, 32'h0, H0, 1, 32'h0, 67, 1, 32'h0, 1, 32'h0, 0, 0);
    vecs[2] = mkv(32'h0, 32'h9, H1, 0, 32'h0, 652, 1, 32'h9, 1, 32'h0, 0, 0);
    vecs[3] = mkv(32'h4CCCCCCD, 32'h50000001, H1, 0, 32'h0, 132, 1, 32'h50000001, 1, 32'h50000000, 1, 32'h50000001);
    vecs[4] = mkv(32'hA0000000, 32'hFFFFFFFF, H1, 0, 32'h0, 2, 0, 0, 0, 0, 0, 0);
    vecs[5] = mkv(32'h00000020, 32'h00000010, H1, 0, 32'h0, 2, 0, 0, 0, 0, 0, 0);
    vecs[6] = mkv(32'h99999998, 32'hFFFFFFFF, H1, 0, 32'h0, 132, 1, 32'h99999999, 1, 32'h99999998, 0, 0);
    vecs[7] = mkv(32'h9999999A, 32'hFFFFFFFF, H1, 0, 32'h0, 2, 0, 0, 0, 0, 0, 0);
    vecs[8] = mkv(32'h0000000B, 32'h00000010, ref_md5(32'h10), 1, 32'h10, 67, 1, 32'h10, 1, 32'h10, 0, 0);
    vecs[9] = mkv(32'h53589793, 32'h53589793, H1, 1, 32'h53589793, 67, 1, 32'h53589793, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {done, found, pass, cand}, 66'h0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_case(vecs[i], $sformatf("vec%0d", i));

    // Abort during HASH, stay idle, then a full restart from normalised low.
    low = vecs[0].lo; high = vecs[0].hi; hash = vecs[0].h; start = 1'b1;
    @(posedge clk);
    repeat (29) @(posedge clk);
    @(negedge clk);
    chk("abort cand@30", cand, 32'h53589790);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("abort outputs", {done, found, pass}, 34'h0);
    any_done = 1'b0;
    repeat (300) begin @(negedge clk); any_done |= done | found; end
    chk("abort idle", any_done, 1'b0);
    run_case(vecs[0], "restart");

    // Reset mid-search, then reset while holding a result in FIN.
    low = vecs[0].lo; high = vecs[0].hi; hash = vecs[0].h; start = 1'b1;
    repeat (40) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("reset_mid", {done, found, pass, cand}, 66'h0);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    low = vecs[9].lo; high = vecs[9].hi; hash = vecs[9].h; start = 1'b1;
    repeat (80) @(negedge clk);
    chk("pre_reset_fin", {done, found, pass}, {2'b11, 32'h53589793});
    reset_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("reset_fin", {done, found, pass, cand}, 66'h0);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int it = 0; it < 16; it++) begin
      n0 = (it == 0) ? 64'd99999997 : longint'($urandom_range(0, 99999999));
      w  = $urandom_range(0, 4);
      nh = (n0 + w > 99999999) ? 64'd99999999 : n0 + w;
      lo_r = to_bcd(n0);
      if ($urandom_range(0, 2) == 0) lo_r[4*$urandom_range(0, 7) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 2) != 0) tgt = to_bcd(n0 + longint'($urandom_range(0, w)));
      else                           tgt = $urandom;
      rv = ref_search(lo_r, to_bcd(nh), ref_md5(tgt));
      run_case(rv, $sformatf("rand%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
